// File: rtl/ldpc_dec_ctrl.sv
// ----------------------------------------------------------------------------
// ldpc_dec_ctrl
//   Frame-level sequencer for ldpc_core. It accepts one codeword at a time,
//   strobes the LLR frame buffer, latches the base-matrix select and clears
//   the core. It then runs the core until core_term rises or the watchdog
//   expires, and holds the status until the consumer takes the result.
//
// Ports
//   clk, rst_n        clock, asynchronous active-low reset
//   in_valid/ready    frame handshake (in_ready = controller idle)
//   in_mode           matrix select, sampled on accept
//   frame_load        1-cycle strobe to the LLR buffer after accept
//   mtx_sel           registered matrix select
//   core_rst          synchronous clear to ldpc_core, CLR_CYC cycles per frame
//   core_en           ldpc_core enable (RUN and no core_term)
//   core_term         ldpc_core termination flag
//   out_valid/ready   result handshake; core res is stable while out_valid
//   out_iter          core_en cycles used for the frame
//   out_conv          terminated below MAX_ITER
//   out_timeout       watchdog fired
//   abort             flush the current frame (ignored when idle)
//   busy              controller not idle
// ----------------------------------------------------------------------------
module ldpc_dec_ctrl #(
    parameter int unsigned MODE_W   = 2,
    parameter int unsigned ITER_W   = 7,
    parameter int unsigned MAX_ITER = 32,
    parameter int unsigned TIMEOUT  = 40,
    parameter int unsigned CLR_CYC  = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [MODE_W-1:0] in_mode,
    output logic              frame_load,
    output logic [MODE_W-1:0] mtx_sel,
    output logic              core_rst,
    output logic              core_en,
    input  logic              core_term,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [ITER_W-1:0] out_iter,
    output logic              out_conv,
    output logic              out_timeout,
    input  logic              abort,
    output logic              busy
);

    localparam int unsigned CLR_W = (CLR_CYC > 1) ? $clog2(CLR_CYC) : 1;
    localparam logic [CLR_W-1:0]  CLR_LAST = CLR_W'(CLR_CYC - 1);
    localparam logic [ITER_W-1:0] TO_LAST  = ITER_W'(TIMEOUT - 1);
    localparam logic [ITER_W-1:0] TO_VAL   = ITER_W'(TIMEOUT);
    localparam logic [ITER_W-1:0] MAX_VAL  = ITER_W'(MAX_ITER);

    typedef enum logic [1:0] {
        S_IDLE,
        S_CLR,
        S_RUN,
        S_DONE
    } state_t;

    state_t             state, state_nxt;
    logic [CLR_W-1:0]   clr_cnt, clr_cnt_nxt;
    logic [ITER_W-1:0]  iter, iter_nxt;

    logic               frame_load_nxt;
    logic [MODE_W-1:0]  mtx_sel_nxt;
    logic               core_rst_nxt;
    logic               out_valid_nxt;
    logic [ITER_W-1:0]  out_iter_nxt;
    logic               out_conv_nxt;
    logic               out_timeout_nxt;
    logic               busy_nxt;

    assign in_ready = (state == S_IDLE);
    assign core_en  = (state == S_RUN) & ~core_term;

    // State register; the registered outputs are loaded from their
    // next-state values so they track the state they belong to.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= S_IDLE;
            clr_cnt     <= '0;
            iter        <= '0;
            frame_load  <= 1'b0;
            mtx_sel     <= '0;
            core_rst    <= 1'b0;
            out_valid   <= 1'b0;
            out_iter    <= '0;
            out_conv    <= 1'b0;
            out_timeout <= 1'b0;
            busy        <= 1'b0;
        end else begin
            state       <= state_nxt;
            clr_cnt     <= clr_cnt_nxt;
            iter        <= iter_nxt;
            frame_load  <= frame_load_nxt;
            mtx_sel     <= mtx_sel_nxt;
            core_rst    <= core_rst_nxt;
            out_valid   <= out_valid_nxt;
            out_iter    <= out_iter_nxt;
            out_conv    <= out_conv_nxt;
            out_timeout <= out_timeout_nxt;
            busy        <= busy_nxt;
        end
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        unique case (state)
            S_IDLE: if (in_valid) state_nxt = S_CLR;
            S_CLR: begin
                if (abort)                    state_nxt = S_IDLE;
                else if (clr_cnt == CLR_LAST) state_nxt = S_RUN;
            end
            S_RUN: begin
                // core_term outranks the watchdog in the same cycle
                if (abort)                  state_nxt = S_IDLE;
                else if (core_term)         state_nxt = S_DONE;
                else if (iter == TO_LAST)   state_nxt = S_DONE;
            end
            S_DONE: if (abort || out_ready) state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    // Output / datapath next values
    always_comb begin
        clr_cnt_nxt     = clr_cnt;
        iter_nxt        = iter;
        frame_load_nxt  = 1'b0;
        mtx_sel_nxt     = mtx_sel;
        out_iter_nxt    = out_iter;
        out_conv_nxt    = out_conv;
        out_timeout_nxt = out_timeout;
        core_rst_nxt    = (state_nxt == S_CLR);
        out_valid_nxt   = (state_nxt == S_DONE);
        busy_nxt        = (state_nxt != S_IDLE);

        unique case (state)
            S_IDLE: begin
                if (in_valid) begin
                    frame_load_nxt = 1'b1;
                    mtx_sel_nxt    = in_mode;
                    clr_cnt_nxt    = '0;
                end
            end
            S_CLR: begin
                clr_cnt_nxt = clr_cnt + CLR_W'(1);
                iter_nxt    = '0;
            end
            S_RUN: begin
                if (core_en && iter != '1) iter_nxt = iter + ITER_W'(1);
                if (!abort) begin
                    if (core_term) begin
                        out_iter_nxt    = iter;
                        out_conv_nxt    = (iter < MAX_VAL);
                        out_timeout_nxt = 1'b0;
                    end else if (iter == TO_LAST) begin
                        out_iter_nxt    = TO_VAL;
                        out_conv_nxt    = 1'b0;
                        out_timeout_nxt = 1'b1;
                    end
                end
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_ldpc_dec_ctrl.sv
module tb_ldpc_dec_ctrl;

    localparam int MODE_W = 2;
    localparam int ITER_W = 7;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              in_valid;
    logic              in_ready;
    logic [MODE_W-1:0] in_mode;
    logic              frame_load;
    logic [MODE_W-1:0] mtx_sel;
    logic              core_rst;
    logic              core_en;
    logic              core_term;
    logic              out_valid;
    logic              out_ready;
    logic [ITER_W-1:0] out_iter;
    logic              out_conv;
    logic              out_timeout;
    logic              abort;
    logic              busy;

    ldpc_dec_ctrl #(
        .MODE_W(2), .ITER_W(7), .MAX_ITER(32), .TIMEOUT(40), .CLR_CYC(2)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready), .in_mode(in_mode),
        .frame_load(frame_load), .mtx_sel(mtx_sel),
        .core_rst(core_rst), .core_en(core_en), .core_term(core_term),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_iter(out_iter), .out_conv(out_conv), .out_timeout(out_timeout),
        .abort(abort), .busy(busy)
    );

    always #5 clk = ~clk;

    // Core model: term rises once term_after enables have been counted
    // since the last clear; term_after < 0 means it never terminates.
    int term_after = -1;
    int mcnt = 0;
    always @(posedge clk) begin
        if (core_rst)     mcnt <= 0;
        else if (core_en) mcnt <= mcnt + 1;
    end
    assign core_term = (term_after >= 0) && (mcnt >= term_after);

    typedef struct {
        int iter;
        bit conv;
        bit to;
    } exp_t;
    exp_t sb[$];
    exp_t e;

    int n_cmp = 0;
    int n_err = 0;
    int obs_fl, obs_rst, obs_en;

    task automatic start_frame(input int mode, input int t_after, input bit push);
        exp_t x;
        term_after = t_after;
        if (push) begin
            if (t_after < 0 || t_after >= 40) begin x.iter = 40; x.conv = 0; x.to = 1; end
            else begin x.iter = t_after; x.conv = (t_after < 32); x.to = 0; end
            sb.push_back(x);
        end
        @(negedge clk);
        in_valid = 1'b1;
        in_mode  = MODE_W'(mode);
        n_cmp++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL accept_ready got=%b want=1", in_ready); end
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    task automatic wait_done();
        bit seen = 0;
        obs_fl = 0; obs_rst = 0; obs_en = 0;
        for (int i = 0; i < 300 && !seen; i++) begin
            @(negedge clk);
            if (frame_load) obs_fl++;
            if (core_rst)   obs_rst++;
            if (core_en)    obs_en++;
            if (out_valid)  seen = 1;
        end
        if (!seen) begin
            n_cmp++; n_err++;
            $display("FAIL done_wait got=no_out_valid want=out_valid within 300 cycles");
        end
    endtask

    task automatic consume(input bit with_abort);
        @(negedge clk);
        out_ready = 1'b1;
        abort     = with_abort;
        @(posedge clk); #1;
        out_ready = 1'b0;
        abort     = 1'b0;
        n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL consume_valid got=%b want=0", out_valid); end
        n_cmp++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL consume_ready got=%b want=1", in_ready); end
    endtask

    task automatic test_reset();
        rst_n = 1'b0; in_valid = 0; in_mode = '0; out_ready = 0; abort = 0;
        #23;
        n_cmp++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL rst_in_ready got=%b want=1", in_ready); end
        n_cmp++; if ({frame_load, core_rst, core_en, out_valid, busy, out_conv, out_timeout} !== 7'b0)
            begin n_err++; $display("FAIL rst_ctrl got=%b want=0000000", {frame_load, core_rst, core_en, out_valid, busy, out_conv, out_timeout}); end
        n_cmp++; if (mtx_sel !== 2'd0 || out_iter !== 7'd0)
            begin n_err++; $display("FAIL rst_regs got=%0d/%0d want=0/0", mtx_sel, out_iter); end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic check_status(input string tag);
        e = sb.pop_front();
        n_cmp++; if (out_valid !== 1'b1) begin n_err++; $display("FAIL %s_valid got=%b want=1", tag, out_valid); end
        n_cmp++; if (out_iter !== ITER_W'(e.iter)) begin n_err++; $display("FAIL %s_iter got=%0d want=%0d", tag, out_iter, e.iter); end
        n_cmp++; if (out_conv !== e.conv) begin n_err++; $display("FAIL %s_conv got=%b want=%b", tag, out_conv, e.conv); end
        n_cmp++; if (out_timeout !== e.to) begin n_err++; $display("FAIL %s_timeout got=%b want=%b", tag, out_timeout, e.to); end
    endtask

    task automatic test_converge();
        start_frame(2, 5, 1);
        wait_done();
        n_cmp++; if (obs_fl != 1) begin n_err++; $display("FAIL conv_frame_load got=%0d want=1", obs_fl); end
        n_cmp++; if (obs_rst != 2) begin n_err++; $display("FAIL conv_core_rst got=%0d want=2", obs_rst); end
        n_cmp++; if (obs_en != 5) begin n_err++; $display("FAIL conv_core_en got=%0d want=5", obs_en); end
        n_cmp++; if (mtx_sel !== 2'd2) begin n_err++; $display("FAIL conv_mtx_sel got=%0d want=2", mtx_sel); end
        check_status("conv");
        consume(0);
    endtask

    task automatic test_max_iter();
        start_frame(1, 33, 1);
        wait_done();
        n_cmp++; if (obs_en != 33) begin n_err++; $display("FAIL maxit_core_en got=%0d want=33", obs_en); end
        n_cmp++; if (mtx_sel !== 2'd1) begin n_err++; $display("FAIL maxit_mtx_sel got=%0d want=1", mtx_sel); end
        check_status("maxit");
        consume(0);
    endtask

    task automatic test_watchdog();
        start_frame(3, -1, 1);
        wait_done();
        n_cmp++; if (obs_en != 40) begin n_err++; $display("FAIL wdog_core_en got=%0d want=40", obs_en); end
        check_status("wdog");
        consume(1); // abort together with out_ready counts as consumed
    endtask

    task automatic test_backpressure();
        start_frame(0, 3, 1);
        wait_done();
        check_status("bp");
        in_valid = 1'b1;
        in_mode  = 2'd3;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            n_cmp++; if ({out_valid, core_en, in_ready, frame_load} !== 4'b1000)
                begin n_err++; $display("FAIL bp_hold_ctrl got=%b want=1000", {out_valid, core_en, in_ready, frame_load}); end
            n_cmp++; if (out_iter !== 7'd3 || out_conv !== 1'b1 || out_timeout !== 1'b0)
                begin n_err++; $display("FAIL bp_hold_status got=%0d/%b/%b want=3/1/0", out_iter, out_conv, out_timeout); end
        end
        term_after = 4;
        sb.push_back('{iter: 4, conv: 1'b1, to: 1'b0});
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        n_cmp++; if (out_valid !== 1'b0 || in_ready !== 1'b1 || frame_load !== 1'b0)
            begin n_err++; $display("FAIL bp_handshake got=%b%b%b want=010", out_valid, in_ready, frame_load); end
        @(posedge clk); #1;
        in_valid = 1'b0;
        n_cmp++; if (frame_load !== 1'b1 || in_ready !== 1'b0 || mtx_sel !== 2'd3)
            begin n_err++; $display("FAIL bp_accept got=%b%b/%0d want=10/3", frame_load, in_ready, mtx_sel); end
        wait_done();
        n_cmp++; if (obs_rst != 2 || obs_en != 4) begin n_err++; $display("FAIL bp_frame2 got=%0d/%0d want=2/4", obs_rst, obs_en); end
        check_status("bp2");
        consume(0);
    endtask

    task automatic test_abort();
        int en_seen = 0;
        bit leaked = 0;
        start_frame(2, 20, 0);
        for (int i = 0; i < 100 && en_seen < 7; i++) begin
            @(negedge clk);
            if (core_en) en_seen++;
        end
        @(posedge clk); #1;   // iter is 7 in this cycle
        abort = 1'b1;
        @(posedge clk); #1;
        abort = 1'b0;
        n_cmp++; if ({busy, in_ready, out_valid, core_en} !== 4'b0100)
            begin n_err++; $display("FAIL abort_idle got=%b want=0100", {busy, in_ready, out_valid, core_en}); end
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            if (out_valid) leaked = 1;
        end
        n_cmp++; if (leaked) begin n_err++; $display("FAIL abort_no_valid got=1 want=0"); end
        n_cmp++; if (out_iter !== 7'd4) begin n_err++; $display("FAIL abort_status_kept got=%0d want=4", out_iter); end
        // abort while idle must not block the same-cycle accept
        abort = 1'b1;
        start_frame(1, 6, 1);
        abort = 1'b0;
        n_cmp++; if (busy !== 1'b1) begin n_err++; $display("FAIL abort_idle_accept got=%b want=1", busy); end
        wait_done();
        n_cmp++; if (obs_rst != 2 || obs_en != 6) begin n_err++; $display("FAIL abort_next got=%0d/%0d want=2/6", obs_rst, obs_en); end
        check_status("abort_next");
        consume(0);
    endtask

    task automatic test_async_reset();
        start_frame(0, 30, 0);
        for (int i = 0; i < 8; i++) @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        n_cmp++; if ({core_en, busy, in_ready, out_valid, core_rst} !== 5'b00100)
            begin n_err++; $display("FAIL arst_drop got=%b want=00100", {core_en, busy, in_ready, out_valid, core_rst}); end
        @(negedge clk);
        rst_n = 1'b1;
        start_frame(2, 5, 1);
        wait_done();
        n_cmp++; if (obs_fl != 1 || obs_rst != 2 || obs_en != 5)
            begin n_err++; $display("FAIL arst_frame got=%0d/%0d/%0d want=1/2/5", obs_fl, obs_rst, obs_en); end
        check_status("arst");
        consume(0);
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout got=running want=finished");
        $fatal(1, "simulation did not finish");
    end

    initial begin
        test_reset();
        test_converge();
        test_max_iter();
        test_watchdog();
        test_backpressure();
        test_abort();
        test_async_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
